// File: rtl/serial_joy_reader.sv
// Reader for a daisy-chained 74HC165-style joystick shift-register chain.
// Generates joy_clk/joy_load, deserialises one frame per FRAME_LEN slots and
// debounces the result across consecutive identical frames.
module serial_joy_reader #(
  parameter int CLK_DIV         = 16,
  parameter int NUM_CHANNELS    = 2,
  parameter int CH_WIDTH        = 12,
  parameter int LEAD_SLOTS      = 2,
  parameter int DEBOUNCE_FRAMES = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             joy_data,
  output logic                             joy_clk,
  output logic                             joy_load,
  output logic [NUM_CHANNELS*CH_WIDTH-1:0] joy_out,
  output logic                             frame_done,
  output logic                             changed
);

  localparam int NBITS     = NUM_CHANNELS * CH_WIDTH;
  localparam int FRAME_LEN = LEAD_SLOTS + NBITS;
  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int SLOT_W    = $clog2(FRAME_LEN);
  localparam int CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEBOUNCE_FRAMES);

  logic [DIV_W-1:0]  div_cnt;
  logic [SLOT_W-1:0] slot;
  logic              data_meta;
  logic              data_sync;
  logic [NBITS-1:0]  raw;
  logic [NBITS-1:0]  raw_next;
  logic [NBITS-1:0]  cand;
  logic [NBITS-1:0]  cand_next;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic              rise_tick;
  logic              end_tick;
  logic              upd;

  // Half-period divider producing the 50% duty shift clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      joy_clk <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
      joy_clk <= ~joy_clk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Rising-edge tick of joy_clk and the last slot of the frame.
  always_comb begin
    rise_tick = (div_cnt == DIV_LAST) && !joy_clk;
    end_tick  = rise_tick && (slot == SLOT_LAST);
  end

  // Slot counter; joy_load moves with the slot so it is low for whole slot-0 periods.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      slot     <= '0;
      joy_load <= 1'b1;
    end else if (rise_tick) begin
      if (slot == SLOT_LAST) begin
        slot     <= '0;
        joy_load <= 1'b0;
      end else begin
        slot     <= slot + 1'b1;
        joy_load <= 1'b1;
      end
    end
  end

  // Two-flop synchroniser for the asynchronous serial input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      data_meta <= joy_data;
      data_sync <= data_meta;
    end
  end

  // Sample placement (slot s -> bit FRAME_LEN-1-s) and debounce decision.
  always_comb begin
    raw_next  = raw;
    cand_next = cand;
    cnt_next  = cnt;
    for (int unsigned i = 0; i < NBITS; i++) begin
      if (rise_tick && (slot == SLOT_W'(FRAME_LEN - 1 - i))) begin
        raw_next[i] = data_sync;
      end
    end
    if (end_tick) begin
      if (raw_next == cand) begin
        cnt_next = (cnt == CNT_FULL) ? cnt : cnt + 1'b1;
      end else begin
        cand_next = raw_next;
        cnt_next  = CNT_W'(1);
      end
    end
    upd = end_tick && (cnt_next == CNT_FULL);
  end

  // Frame, candidate and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      raw        <= '1;
      cand       <= '1;
      cnt        <= '0;
      joy_out    <= '1;
      frame_done <= 1'b0;
      changed    <= 1'b0;
    end else begin
      raw        <= raw_next;
      cand       <= cand_next;
      cnt        <= cnt_next;
      frame_done <= end_tick;
      changed    <= upd && (cand_next != joy_out);
      if (upd) begin
        joy_out <= cand_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_joy_reader.sv
// Directed bench for serial_joy_reader: default instance plus a 4x8 variant.
module tb_serial_joy_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        joy_data_a = 1'b1;
  logic        joy_clk_a, joy_load_a, frame_done_a, changed_a;
  logic [23:0] joy_out_a;
  logic        joy_data_b = 1'b1;
  logic        joy_clk_b, joy_load_b, frame_done_b, changed_b;
  logic [31:0] joy_out_b;

  int          cyc   = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          slot_a = 0;
  int          slot_b = 0;
  logic [23:0] next_a, cur_a;
  logic [31:0] next_b, cur_b;
  int          t1, t2, tp, n;
  logic        hit;

  serial_joy_reader dut_a (
    .clock(clock), .reset(reset), .joy_data(joy_data_a), .joy_clk(joy_clk_a),
    .joy_load(joy_load_a), .joy_out(joy_out_a), .frame_done(frame_done_a),
    .changed(changed_a)
  );

  serial_joy_reader #(
    .CLK_DIV(2), .NUM_CHANNELS(4), .CH_WIDTH(8), .LEAD_SLOTS(1), .DEBOUNCE_FRAMES(1)
  ) dut_b (
    .clock(clock), .reset(reset), .joy_data(joy_data_b), .joy_clk(joy_clk_b),
    .joy_load(joy_load_b), .joy_out(joy_out_b), .frame_done(frame_done_b),
    .changed(changed_b)
  );

  always #5 clock = ~clock;

  // Free-running cycle counter for period measurements.
  always @(posedge clock) cyc <= cyc + 1;

  // Chain model A: after each joy_clk rise, present the bit for the new slot.
  always @(posedge joy_clk_a or posedge reset or negedge reset) begin
    if (reset) begin
      slot_a     = 0;
      cur_a      = next_a;
      joy_data_a = 1'b1;
    end else if (!joy_clk_a) begin
      cur_a = next_a;
    end else begin
      slot_a = (slot_a == 25) ? 0 : slot_a + 1;
      if (slot_a == 0) cur_a = next_a;
      joy_data_a = (slot_a >= 2) ? cur_a[23 - (slot_a - 2)] : 1'b1;
    end
  end

  // Chain model B: one lead slot, 32 data slots.
  always @(posedge joy_clk_b or posedge reset or negedge reset) begin
    if (reset) begin
      slot_b     = 0;
      cur_b      = next_b;
      joy_data_b = 1'b1;
    end else if (!joy_clk_b) begin
      cur_b = next_b;
    end else begin
      slot_b = (slot_b == 32) ? 0 : slot_b + 1;
      if (slot_b == 0) cur_b = next_b;
      joy_data_b = (slot_b >= 1) ? cur_b[31 - (slot_b - 1)] : 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait for the next frame_done pulse of instance a (sel=0) or b (sel=1).
  task automatic wait_fd(input bit sel, output int t);
    int  k = 0;
    bit  seen = 1'b0;
    while (!seen && k < 1500) begin
      @(negedge clock);
      k++;
      seen = sel ? frame_done_b : frame_done_a;
    end
    n_cmp++;
    assert (seen) else begin
      n_err++;
      $error("FAIL wait_fd%0d: observed no pulse in %0d cycles expected one", sel, k);
    end
    t = cyc;
  endtask

  initial begin
    reset  = 1'b1;
    next_a = 24'hA5F00F;
    next_b = 32'hDEADBEEF;
    repeat (5) @(posedge clock);
    @(negedge clock);
    check("rst_joy_clk",    32'(joy_clk_a),    32'd0);
    check("rst_joy_load",   32'(joy_load_a),   32'd1);
    check("rst_joy_out",    32'(joy_out_a),    32'h00FFFFFF);
    check("rst_frame_done", 32'(frame_done_a), 32'd0);
    check("rst_changed",    32'(changed_a),    32'd0);
    reset = 1'b0;

    // First two frames of a stable pattern.
    wait_fd(1'b0, t1);
    check("fd1_out",     32'(joy_out_a),  32'h00FFFFFF);
    check("fd1_changed", 32'(changed_a),  32'd0);
    check("fd1_load",    32'(joy_load_a), 32'd0);
    n = 0;
    while (joy_load_a == 1'b0 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("load_low_len", 32'(n), 32'd32);
    wait_fd(1'b0, t2);
    check("period",      32'(t2 - t1),   32'd832);
    check("fd2_out",     32'(joy_out_a), 32'h00A5F00F);
    check("fd2_changed", 32'(changed_a), 32'd1);

    // Switch to 123456: frame 3 still carries A5F00F.
    next_a = 24'h123456;
    wait_fd(1'b0, t1);
    check("fd3_out",     32'(joy_out_a), 32'h00A5F00F);
    check("fd3_changed", 32'(changed_a), 32'd0);
    wait_fd(1'b0, t1);
    check("fd4_out",     32'(joy_out_a), 32'h00A5F00F);
    wait_fd(1'b0, t1);
    check("fd5_out",     32'(joy_out_a), 32'h00123456);
    check("fd5_changed", 32'(changed_a), 32'd1);

    // Single glitch frame of zeros.
    next_a = 24'h000000;
    wait_fd(1'b0, t1);
    check("fd6_out",     32'(joy_out_a), 32'h00123456);
    next_a = 24'h123456;
    for (int i = 0; i < 3; i++) begin
      wait_fd(1'b0, t1);
      check("glitch_out",     32'(joy_out_a), 32'h00123456);
      check("glitch_changed", 32'(changed_a), 32'd0);
    end

    // Ten more identical frames.
    tp = t1;
    for (int i = 0; i < 10; i++) begin
      wait_fd(1'b0, t2);
      check("stable_period",  32'(t2 - tp),   32'd832);
      check("stable_out",     32'(joy_out_a), 32'h00123456);
      check("stable_changed", 32'(changed_a), 32'd0);
      tp = t2;
    end

    // Reset in mid-frame at slot 10.
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 1000) begin
      @(negedge clock);
      n++;
      hit = (slot_a == 10);
    end
    check("reach_slot10", 32'(hit), 32'd1);
    repeat (5) @(negedge clock);
    next_a = 24'h0F0F0F;
    reset  = 1'b1;
    #1;
    check("mid_rst_joy_out",  32'(joy_out_a),    32'h00FFFFFF);
    check("mid_rst_joy_clk",  32'(joy_clk_a),    32'd0);
    check("mid_rst_joy_load", 32'(joy_load_a),   32'd1);
    check("mid_rst_fd",       32'(frame_done_a), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    wait_fd(1'b0, t1);
    check("post_rst_fd1_out",  32'(joy_out_a),  32'h00FFFFFF);
    check("post_rst_fd1_load", 32'(joy_load_a), 32'd0);
    repeat (40) @(negedge clock);
    check("post_rst_load_hi",  32'(joy_load_a), 32'd1);
    wait_fd(1'b0, t2);
    check("post_rst_fd2_out",     32'(joy_out_a), 32'h000F0F0F);
    check("post_rst_fd2_changed", 32'(changed_a), 32'd1);

    // 4x8 instance, lead 1, no debounce.
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_fd(1'b1, t1);
    check("b_fd1_out",     joy_out_b,           32'hDEADBEEF);
    check("b_fd1_ch0",     32'(joy_out_b[7:0]), 32'h000000EF);
    check("b_fd1_changed", 32'(changed_b),      32'd1);
    wait_fd(1'b1, t2);
    check("b_period",      32'(t2 - t1),        32'd132);
    check("b_fd2_out",     joy_out_b,           32'hDEADBEEF);
    check("b_fd2_changed", 32'(changed_b),      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
